// File: rtl/mc_pkg.sv
// Shared encodings for the parametrised multicycle core:
// FSM states, instruction opcodes and ALU operation codes.
package mc_pkg;

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_HALT   = 3'd5;

   localparam logic [3:0] OP_LOAD  = 4'b0000;
   localparam logic [3:0] OP_STOP  = 4'b0001;
   localparam logic [3:0] OP_STORE = 4'b0010;
   localparam logic [3:0] OP_ADD   = 4'b0100;
   localparam logic [3:0] OP_BZ    = 4'b0101;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_NAND  = 4'b1000;
   localparam logic [3:0] OP_BNZ   = 4'b1001;
   localparam logic [3:0] OP_NOP   = 4'b1010;
   localparam logic [3:0] OP_BPZ   = 4'b1101;

   localparam logic [2:0] ALU_ADD  = 3'd0;
   localparam logic [2:0] ALU_SUB  = 3'd1;
   localparam logic [2:0] ALU_NAND = 3'd2;
   localparam logic [2:0] ALU_OR   = 3'd3;
   localparam logic [2:0] ALU_SHL  = 3'd4;
   localparam logic [2:0] ALU_SHR  = 3'd5;

endpackage

// File: rtl/mc_alu_p.sv
// Combinational ALU: add/sub/nand/or and zero-fill shifts,
// with negative and zero indications of the result.
module mc_alu_p
   import mc_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [2:0]        i_op,
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   input  logic [2:0]        i_sh,
   output logic [DATA_W-1:0] o_y,
   output logic              o_n,
   output logic              o_z
);

   always_comb begin
      o_y = '0;
      case (i_op)
         ALU_ADD:  o_y = i_a + i_b;
         ALU_SUB:  o_y = i_a - i_b;
         ALU_NAND: o_y = ~(i_a & i_b);
         ALU_OR:   o_y = i_a | i_b;
         ALU_SHL:  o_y = i_a << i_sh;
         ALU_SHR:  o_y = i_a >> i_sh;
         default:  o_y = '0;
      endcase
   end

   assign o_n = o_y[DATA_W-1];
   assign o_z = ~|o_y;

endmodule

// File: rtl/multicycle_core_p.sv
// Parametrised multicycle core running the 8-bit ISA over a
// wait-state tolerant memory handshake, with a saturating cycle counter.
module multicycle_core_p
   import mc_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8,
   parameter int PERF_W = 16
) (
   input  logic              clock,
   input  logic              reset,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   input  logic [1:0]        dbg_sel,
   output logic [DATA_W-1:0] dbg_reg,
   output logic [ADDR_W-1:0] pc,
   output logic [7:0]        ir,
   output logic              flag_n,
   output logic              flag_z,
   output logic              halted,
   output logic [PERF_W-1:0] perf_count
);

   logic [2:0]        r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [7:0]        r_ir;
   logic [DATA_W-1:0] r_regs [4];
   logic              r_n, r_z;
   logic              r_rn, r_rz;
   logic [DATA_W-1:0] r_a, r_b, r_res;
   logic [PERF_W-1:0] r_perf;

   logic [3:0]        w_op;
   logic [1:0]        w_ra, w_rb, w_dst;
   logic              w_ori, w_shift, w_arith, w_alu;
   logic              w_load, w_store, w_stop, w_take;
   logic [2:0]        w_aluop;
   logic [ADDR_W-1:0] w_off;
   logic [DATA_W-1:0] w_bsel, w_y;
   logic              w_yn, w_yz;

   assign w_op    = r_ir[3:0];
   assign w_ra    = r_ir[7:6];
   assign w_rb    = r_ir[5:4];
   assign w_ori   = (r_ir[2:0] == 3'b111);
   assign w_shift = !w_ori && (r_ir[1:0] == 2'b11);
   assign w_arith = (w_op == OP_ADD) || (w_op == OP_SUB)
                 || (w_op == OP_NAND);
   assign w_alu   = w_ori || w_shift || w_arith;
   assign w_load  = (w_op == OP_LOAD);
   assign w_store = (w_op == OP_STORE);
   assign w_stop  = (w_op == OP_STOP);
   assign w_dst   = w_ori ? 2'd1 : w_ra;

   assign w_take = ((w_op == OP_BZ)  &&  r_z)
                || ((w_op == OP_BNZ) && !r_z)
                || ((w_op == OP_BPZ) && !r_n);

   // pc already points past the branch here, so only imm4 is added
   assign w_off  = ADDR_W'({{28{r_ir[7]}}, r_ir[7:4]});
   assign w_bsel = w_ori ? DATA_W'(r_ir[7:3]) : r_b;

   always_comb begin
      w_aluop = ALU_ADD;
      unique case (1'b1)
         w_ori:              w_aluop = ALU_OR;
         w_shift:            w_aluop = r_ir[3] ? ALU_SHL : ALU_SHR;
         (w_op == OP_SUB):   w_aluop = ALU_SUB;
         (w_op == OP_NAND):  w_aluop = ALU_NAND;
         default:            w_aluop = ALU_ADD;
      endcase
   end

   mc_alu_p #(.DATA_W(DATA_W)) u_alu (
      .i_op (w_aluop),
      .i_a  (r_a),
      .i_b  (w_bsel),
      .i_sh (r_ir[5:3]),
      .o_y  (w_y),
      .o_n  (w_yn),
      .o_z  (w_yz)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_FETCH;
         r_pc    <= '0;
         r_ir    <= '0;
         r_n     <= 1'b0;
         r_z     <= 1'b0;
         r_rn    <= 1'b0;
         r_rz    <= 1'b0;
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_perf  <= '0;
         for (int i = 0; i < 4; i++) r_regs[i] <= '0;
      end else begin
         if (r_state != S_HALT && r_perf != '1)
            r_perf <= r_perf + PERF_W'(1);
         unique case (r_state)
            S_FETCH: if (mem_ready) begin
               r_ir    <= mem_rdata[7:0];
               r_pc    <= r_pc + ADDR_W'(1);
               r_state <= S_DECODE;
            end
            S_DECODE: begin
               r_a <= r_regs[w_dst];
               r_b <= r_regs[w_rb];
               if (w_stop)
                  r_state <= S_HALT;
               else if (w_load || w_store)
                  r_state <= S_MEM;
               else begin
                  r_state <= S_EXEC;
                  if (w_take) r_pc <= r_pc + w_off;
               end
            end
            S_EXEC: begin
               r_res   <= w_y;
               r_rn    <= w_yn;
               r_rz    <= w_yz;
               r_state <= w_alu ? S_WB : S_FETCH;
            end
            S_MEM: if (mem_ready) begin
               if (w_load) begin
                  r_res   <= mem_rdata;
                  r_state <= S_WB;
               end else
                  r_state <= S_FETCH;
            end
            S_WB: begin
               r_regs[w_dst] <= r_res;
               if (w_alu) begin
                  r_n <= r_rn;
                  r_z <= r_rz;
               end
               r_state <= S_FETCH;
            end
            default: ;
         endcase
      end
   end

   // reset kills any in-flight request the same cycle it is seen
   assign mem_req   = !reset
                   && (r_state == S_FETCH || r_state == S_MEM);
   assign mem_we    = !reset && (r_state == S_MEM) && w_store;
   assign mem_addr  = (r_state == S_MEM) ? r_b[ADDR_W-1:0] : r_pc;
   assign mem_wdata = r_a;

   assign dbg_reg    = r_regs[dbg_sel];
   assign pc         = r_pc;
   assign ir         = r_ir;
   assign flag_n     = r_n;
   assign flag_z     = r_z;
   assign halted     = (r_state == S_HALT);
   assign perf_count = r_perf;

endmodule

// File: tb/tb_multicycle_core_p.sv
// Directed bench for multicycle_core_p: an 8-bit/4-bit-counter instance
// and a 16-bit instance with three wait states per request.
module tb_multicycle_core_p;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // instance A: DATA_W=8, ADDR_W=8, PERF_W=4
   logic       rst_a = 1'b1;
   logic       req_a, we_a, rdy_a;
   logic [7:0] addr_a, wdata_a, rdata_a, dbgr_a, pc_a, ir_a;
   logic [1:0] dbg_a = 2'd0;
   logic       n_a, z_a, halt_a;
   logic [3:0] perf_a;

   // instance B: DATA_W=16, ADDR_W=8, PERF_W=16
   logic        rst_b = 1'b1;
   logic        req_b, we_b, rdy_b;
   logic [7:0]  addr_b, pc_b, ir_b;
   logic [15:0] wdata_b, rdata_b, dbgr_b, perf_b;
   logic [1:0]  dbg_b = 2'd0;
   logic        n_b, z_b, halt_b;

   multicycle_core_p #(.DATA_W(8), .ADDR_W(8), .PERF_W(4)) u_a (
      .clock(clk), .reset(rst_a),
      .mem_req(req_a), .mem_we(we_a), .mem_addr(addr_a),
      .mem_wdata(wdata_a), .mem_rdata(rdata_a), .mem_ready(rdy_a),
      .dbg_sel(dbg_a), .dbg_reg(dbgr_a), .pc(pc_a), .ir(ir_a),
      .flag_n(n_a), .flag_z(z_a), .halted(halt_a),
      .perf_count(perf_a)
   );

   multicycle_core_p #(.DATA_W(16), .ADDR_W(8), .PERF_W(16)) u_b (
      .clock(clk), .reset(rst_b),
      .mem_req(req_b), .mem_we(we_b), .mem_addr(addr_b),
      .mem_wdata(wdata_b), .mem_rdata(rdata_b), .mem_ready(rdy_b),
      .dbg_sel(dbg_b), .dbg_reg(dbgr_b), .pc(pc_b), .ir(ir_b),
      .flag_n(n_b), .flag_z(z_b), .halted(halt_b),
      .perf_count(perf_b)
   );

   // memory A: zero wait, writes can be stalled or forced ready
   logic [7:0] mem_a [256];
   logic       force_a = 1'b0;
   logic       hold_wr_a = 1'b0;
   int         nwr_a = 0;
   assign rdata_a = mem_a[addr_a];
   assign rdy_a   = force_a | !(hold_wr_a && we_a);
   always @(posedge clk)
      if (req_a && we_a && rdy_a) nwr_a <= nwr_a + 1;

   // memory B: exactly three wait cycles before each ready
   logic [15:0] mem_b [256];
   int          wcnt_b = 0;
   int          nreq_b = 0;
   assign rdata_b = mem_b[addr_b];
   assign rdy_b   = (wcnt_b >= 3);
   always @(posedge clk) begin
      if (req_b && !rdy_b) wcnt_b <= wcnt_b + 1;
      else                 wcnt_b <= 0;
      if (req_b && rdy_b)  nreq_b <= nreq_b + 1;
   end

   // request must hold with a stable address until handshake
   int         hs_err_b = 0;
   logic       pend_b = 1'b0;
   logic [7:0] paddr_b = '0;
   always @(negedge clk) begin
      if (pend_b && (!req_b || addr_b !== paddr_b))
         hs_err_b <= hs_err_b + 1;
      pend_b  <= req_b && !rdy_b;
      paddr_b <= addr_b;
   end

   // saturating counter must never fall back to zero
   int   wrap_err_a = 0;
   logic was_nz_a = 1'b0;
   always @(negedge clk) begin
      if (!rst_a && was_nz_a && perf_a == 4'd0)
         wrap_err_a <= wrap_err_a + 1;
      was_nz_a <= !rst_a && (perf_a != 4'd0);
   end

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic push(input string t, input logic [31:0] v);
      exp_t e;
      e.tag = t;
      e.val = v;
      q.push_back(e);
   endtask

   task automatic pop_cmp(input logic [31:0] obs);
      exp_t e;
      n_cmp++;
      if (q.size() == 0) begin
         n_bad++;
         $error("FAIL scoreboard_empty observed=%0h", obs);
         return;
      end
      e = q.pop_front();
      assert (obs === e.val) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h",
                e.tag, obs, e.val);
      end
   endtask

   task automatic clear_a();
      for (int i = 0; i < 256; i++) mem_a[i] = 8'h01;
   endtask

   task automatic reset_a();
      rst_a = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic run_a(input int budget);
      int n = 0;
      rst_a = 1'b0;
      while (!halt_a && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic wait_ir_a(input logic [7:0] v);
      int n = 0;
      while (ir_a !== v && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   initial begin
      int n;
      for (int i = 0; i < 256; i++) mem_b[i] = 16'h0001;
      clear_a();

      // reset state
      push("rst_pc", 0);
      push("rst_ir", 0);
      push("rst_perf", 0);
      push("rst_req", 0);
      push("rst_halted", 0);
      reset_a();
      pop_cmp(pc_a);
      pop_cmp(ir_a);
      pop_cmp(perf_a);
      pop_cmp(req_a);
      pop_cmp(halt_a);

      // ORI 5; ADD R1,R1; STOP
      mem_a[0] = 8'h2F;
      mem_a[1] = 8'h54;
      mem_a[2] = 8'h01;
      push("p1_r1", 8'h0A);
      push("p1_n", 0);
      push("p1_z", 0);
      push("p1_halted", 1);
      push("p1_perf", 10);
      push("p1_pc", 3);
      run_a(60);
      dbg_a = 2'd1;
      #1;
      pop_cmp(dbgr_a);
      pop_cmp(n_a);
      pop_cmp(z_a);
      pop_cmp(halt_a);
      pop_cmp(perf_a);
      pop_cmp(pc_a);

      // ORI 1; SUB R0,R1 -> 0x00-0x01
      clear_a();
      mem_a[0] = 8'h0F;
      mem_a[1] = 8'h16;
      push("sub_r0", 8'hFF);
      push("sub_n", 1);
      push("sub_z", 0);
      reset_a();
      run_a(60);
      dbg_a = 2'd0;
      #1;
      pop_cmp(dbgr_a);
      pop_cmp(n_a);
      pop_cmp(z_a);

      // R0=0xFF then NAND R0,R0
      mem_a[2] = 8'h08;
      push("nand_r0", 8'h00);
      push("nand_z", 1);
      push("nand_n", 0);
      reset_a();
      run_a(60);
      pop_cmp(dbgr_a);
      pop_cmp(z_a);
      pop_cmp(n_a);

      // ORI 1; SHL R1 by 7; 3x NOP; STOP -> 19 cycles
      clear_a();
      mem_a[0] = 8'h0F;
      mem_a[1] = 8'h7B;
      mem_a[2] = 8'h0A;
      mem_a[3] = 8'h0A;
      mem_a[4] = 8'h0A;
      push("shl_r1", 8'h80);
      push("shl_n", 1);
      push("shl_z", 0);
      push("sat_perf", 4'hF);
      push("sat_nowrap", 0);
      reset_a();
      run_a(60);
      repeat (4) @(posedge clk);
      #1;
      dbg_a = 2'd1;
      #1;
      pop_cmp(dbgr_a);
      pop_cmp(n_a);
      pop_cmp(z_a);
      pop_cmp(perf_a);
      pop_cmp(wrap_err_a);

      // SUB R0,R0; BPZ -4 -> 0xFE; BZ +3 -> wraps to 0x02
      clear_a();
      mem_a[0]   = 8'h06;
      mem_a[1]   = 8'hCD;
      mem_a[254] = 8'h35;
      push("bz_ir", 8'h35);
      push("bz_pc", 8'h02);
      push("bz_end_pc", 8'h03);
      push("bz_halted", 1);
      reset_a();
      rst_a = 1'b0;
      wait_ir_a(8'h35);
      pop_cmp(ir_a);
      @(posedge clk);
      #1;
      pop_cmp(pc_a);
      run_a(60);
      pop_cmp(pc_a);
      pop_cmp(halt_a);

      // same prologue, BNZ +3 with Z=1 falls through
      mem_a[254] = 8'h39;
      mem_a[255] = 8'h01;
      push("bnz_ir", 8'h39);
      push("bnz_pc", 8'hFF);
      push("bnz_end_pc", 8'h00);
      reset_a();
      rst_a = 1'b0;
      wait_ir_a(8'h39);
      pop_cmp(ir_a);
      @(posedge clk);
      #1;
      pop_cmp(pc_a);
      run_a(60);
      pop_cmp(pc_a);

      // STORE stalled in MEM, reset with ready forced high
      clear_a();
      mem_a[0]  = 8'h12;
      hold_wr_a = 1'b1;
      push("st_we", 1);
      push("st_rst_pc", 0);
      push("st_rst_req", 0);
      push("st_no_write", 0);
      push("st_re_req", 1);
      push("st_re_addr", 0);
      push("st_re_we", 0);
      reset_a();
      rst_a = 1'b0;
      n = 0;
      while (!(req_a && we_a) && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      pop_cmp(we_a);
      rst_a   = 1'b1;
      force_a = 1'b1;
      @(posedge clk);
      #1;
      pop_cmp(pc_a);
      pop_cmp(req_a);
      pop_cmp(nwr_a);
      rst_a   = 1'b0;
      force_a = 1'b0;
      #1;
      pop_cmp(req_a);
      pop_cmp(addr_a);
      pop_cmp(we_a);
      hold_wr_a = 1'b0;

      // 16-bit: R1=0x40 via ORI/ADD/ADD, LOAD R0,[R1], STOP
      mem_b[0]     = 16'h0087;
      mem_b[1]     = 16'h0054;
      mem_b[2]     = 16'h0054;
      mem_b[3]     = 16'h0010;
      mem_b[8'h40] = 16'hBEEF;
      push("ws_r0", 16'hBEEF);
      push("ws_r1", 16'h0040);
      push("ws_perf", 36);
      push("ws_reqs", 6);
      push("ws_handshake", 0);
      push("ws_pc", 5);
      rst_b = 1'b0;
      n = 0;
      while (!halt_b && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      dbg_b = 2'd0;
      #1;
      pop_cmp(dbgr_b);
      dbg_b = 2'd1;
      #1;
      pop_cmp(dbgr_b);
      pop_cmp(perf_b);
      pop_cmp(nreq_b);
      pop_cmp(hs_err_b);
      pop_cmp(pc_b);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

endmodule
